// File: rtl/div_pkg.sv
// Shared definitions for the sequential 6-bit divider.
//   DIV_WIDTH    : operand width (6)
//   DBZ_QUOTIENT : quotient reported when the divisor is zero
//   state_e      : divider control states
package div_pkg;

  localparam int DIV_WIDTH = 6;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = 6'h3F;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_run  = 2'd1,
    st_done = 2'd2
  } state_e;

endpackage : div_pkg

// File: rtl/fa_1bit.sv
// 1-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module fa_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_1bit

// File: rtl/sub_7bit.sv
// Combinational ripple subtractor: diff = a - b.
// Built as a + ~b + 1 from full-adder cells; a missing final carry means
// the subtraction borrowed (a < b).
//   a, b       : minuend and subtrahend
//   diff       : a - b modulo 2**W
//   borrow_out : 1 when a < b
module sub_7bit #(
  parameter int W = 7
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_1bit u_fa (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow_out = ~carry[W];

endmodule : sub_7bit

// File: rtl/div_6bit_seq.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request a division (only looked at while idle)
//   dividend, divisor   : unsigned operands, captured on the accepted start
//   busy                : high while running or presenting a result
//   done                : one-cycle result-valid pulse
//   quotient, remainder : registered result, held until the next result
//   div_by_zero         : qualifies the last result as a divide by zero
module div_6bit_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CW        = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_STEP = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q;     // dividend, shifted left one bit per step
  logic [WIDTH-1:0] dvs_q;     // latched divisor
  logic [WIDTH-1:0] qacc_q;    // quotient bits collected so far
  logic [WIDTH:0]   r_q;       // partial remainder R
  logic [CW-1:0]    cnt_q;     // steps completed

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_next;
  logic             borrow;
  logic             qbit;
  logic             last_step;
  logic             r_msb_unused;

  // Shift the next dividend bit into R and try subtracting the divisor.
  assign shifted = {r_q[WIDTH-1:0], dvd_q[WIDTH-1]};

  sub_7bit #(.W(WIDTH + 1)) u_sub (
    .a          (shifted),
    .b          ({1'b0, dvs_q}),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // Restoring step: keep the difference only when it did not go negative.
  assign qbit      = ~borrow;
  assign r_next    = borrow ? shifted : trial;
  assign last_step = (cnt_q == LAST_STEP);

  // R stays below the divisor after every step, so its MSB is always zero
  // and is only needed as headroom inside the trial subtraction.
  assign r_msb_unused = r_q[WIDTH];

  assign busy = (state_q != st_idle);
  assign done = (state_q == st_done);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= st_idle;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle: if (start) state_d = (divisor == '0) ? st_done : st_run;
      st_run:  if (last_step) state_d = st_done;
      st_done: state_d = st_idle;
      default: state_d = st_idle;
    endcase
  end

  // NOTE: the working registers are reset along with the outputs so that an
  // aborted division leaves no stale partial result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      qacc_q      <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        st_idle: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            qacc_q <= '0;
            r_q    <= '0;
            cnt_q  <= '0;
            if (divisor == '0) begin
              quotient    <= DBZ_QUOTIENT;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        st_run: begin
          r_q    <= r_next;
          dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
          qacc_q <= {qacc_q[WIDTH-2:0], qbit};
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            quotient    <= {qacc_q[WIDTH-2:0], qbit};
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule : div_6bit_seq

// File: tb/tb_div_6bit_seq.sv
// Self-checking bench for div_6bit_seq: directed vector table, hand-written
// corner sequences (start ignored while busy, reset mid-run, start right
// after reset) and an exhaustive sweep of all non-zero-divisor pairs with
// randomised operand wiggling after the start is accepted.
module tb_div_6bit_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] dividend;
  logic [5:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  div_6bit_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] q;
    logic [5:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention.
  task automatic model(input logic [5:0] a, input logic [5:0] b,
                       output logic [5:0] q, output logic [5:0] r, output logic dbz);
    if (b == 0) begin
      q = 6'h3F; r = a; dbz = 1'b1;
    end else begin
      q = a / b; r = a % b; dbz = 1'b0;
    end
  endtask

  // Call in the low phase of the clock. Issues one division, checks busy
  // each cycle until done, then checks done lasts exactly one cycle.
  // Returns at a negedge in the idle cycle after done.
  task automatic run_div(input logic [5:0] a, input logic [5:0] b, input bit wiggle,
                         output logic [5:0] q, output logic [5:0] r,
                         output logic dbz, output int lat);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (wiggle) begin
      dividend = 6'($urandom);
      divisor  = 6'($urandom);
    end
    lat = 0;
    q = '0; r = '0; dbz = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (done) begin
        lat = i;
        q = quotient; r = remainder; dbz = div_by_zero;
        check($sformatf("busy_at_done %0d/%0d", a, b), busy, 1);
        break;
      end
      check($sformatf("busy_run %0d/%0d", a, b), busy, 1);
      @(negedge clk);
    end
    if (lat == 0) begin
      check($sformatf("done_timeout %0d/%0d", a, b), 0, 1);
    end else begin
      @(negedge clk);
      check($sformatf("done_one_cycle %0d/%0d", a, b), done, 0);
      check($sformatf("idle_after_done %0d/%0d", a, b), busy, 0);
    end
  endtask

  initial begin
    vec_t       vecs[8];
    logic [5:0] q, r, eq, er;
    logic       dbz, edbz;
    int         lat, ndone;

    vecs = '{
      '{6'd45, 6'd7,  6'd6,  6'd3,  1'b0, 7},
      '{6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 7},
      '{6'd5,  6'd9,  6'd0,  6'd5,  1'b0, 7},
      '{6'd20, 6'd0,  6'h3F, 6'd20, 1'b1, 1},
      '{6'd20, 6'd4,  6'd5,  6'd0,  1'b0, 7},
      '{6'd0,  6'd63, 6'd0,  6'd0,  1'b0, 7},
      '{6'd63, 6'd63, 6'd1,  6'd0,  1'b0, 7},
      '{6'd62, 6'd63, 6'd0,  6'd62, 1'b0, 7}
    };

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; runs back to back, each start in the cycle after done.
    for (int i = 0; i < 8; i++) begin
      run_div(vecs[i].a, vecs[i].b, 1'b0, q, r, dbz, lat);
      check($sformatf("vec%0d quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d dbz", i), dbz, vecs[i].dbz);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d hold_quotient", i), quotient, vecs[i].q);
    end

    // Start ignored while busy: 60/7, then 9/3 offered at edge T+3.
    dividend = 6'd60; divisor = 6'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    dividend = 6'd9; divisor = 6'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ndone = 0; q = '0; r = '0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        ndone++;
        q = quotient; r = remainder;
      end
      @(negedge clk);
    end
    check("ignore_start done_count", ndone, 1);
    check("ignore_start quotient", q, 8);
    check("ignore_start remainder", r, 4);

    // Reset in the middle of 45/7.
    dividend = 6'd45; divisor = 6'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset busy", busy, 0);
    check("async_reset done", done, 0);
    check("async_reset quotient", quotient, 0);
    check("async_reset remainder", remainder, 0);
    check("async_reset dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    run_div(6'd12, 6'd5, 1'b0, q, r, dbz, lat);
    check("after_reset quotient", q, 2);
    check("after_reset remainder", r, 2);
    check("after_reset latency", lat, 7);

    // Start honoured on the first edge after reset release.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    run_div(6'd7, 6'd2, 1'b0, q, r, dbz, lat);
    check("first_edge quotient", q, 3);
    check("first_edge remainder", r, 1);
    check("first_edge latency", lat, 7);

    // Exhaustive non-zero-divisor sweep with operands wiggled after start.
    for (int b = 1; b < 64; b++) begin
      for (int a = 0; a < 64; a++) begin
        run_div(6'(a), 6'(b), 1'b1, q, r, dbz, lat);
        model(6'(a), 6'(b), eq, er, edbz);
        check($sformatf("sweep %0d/%0d invariant", a, b), 32'(q) * 32'(b) + 32'(r), a);
        check($sformatf("sweep %0d/%0d rem_lt_div", a, b), 32'(r < 6'(b)), 1);
        check($sformatf("sweep %0d/%0d quotient", a, b), q, eq);
        check($sformatf("sweep %0d/%0d remainder", a, b), r, er);
        check($sformatf("sweep %0d/%0d dbz", a, b), dbz, edbz);
      end
    end

    // Random pairs including zero divisors.
    for (int i = 0; i < 200; i++) begin
      logic [5:0] ra, rb;
      ra = 6'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      run_div(ra, rb, 1'b1, q, r, dbz, lat);
      model(ra, rb, eq, er, edbz);
      check($sformatf("rand %0d/%0d quotient", ra, rb), q, eq);
      check($sformatf("rand %0d/%0d remainder", ra, rb), r, er);
      check($sformatf("rand %0d/%0d dbz", ra, rb), dbz, edbz);
      check($sformatf("rand %0d/%0d latency", ra, rb), lat, (rb == 0) ? 1 : 7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_div_6bit_seq

// File: doc/div_6bit_seq.md
DIV_6BIT_SEQ -- requirements
Module: div_6bit_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-002 SHALL have parameter WIDTH, default 6, giving the operand width; only 6 is verified.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 SHALL have port dividend, input, 6 bits: unsigned dividend, captured on the accepted start.
REQ-007 SHALL have port divisor, input, 6 bits: unsigned divisor, captured on the accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-010 SHALL have port quotient, output, 6 bits: registered quotient.
REQ-011 SHALL have port remainder, output, 6 bits: registered remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: registered flag qualifying the last result.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1 at edge T, latch the operands, clear the partial remainder R (7 bits) and the iteration count, and enter RUN; when divisor=0, it SHALL instead enter DONE directly.
REQ-015 SHALL perform one restoring step per RUN cycle, MSB first: trial = {R[5:0], next dividend bit} - {1'b0, divisor} (7 bits); when there is no borrow, R = trial and the quotient bit = 1; otherwise R = the shifted value and the quotient bit = 0.
REQ-016 SHALL complete exactly 6 steps, at edges T+1..T+6; at edge T+6 it SHALL load quotient and remainder (R[5:0]) and enter DONE.
REQ-017 SHALL assert done only in DONE, for exactly one cycle (the cycle after edge T+6), and SHALL then return to IDLE.
REQ-018 SHALL hold quotient, remainder and div_by_zero stable from their load until the next result load.
REQ-019 SHALL, on divide-by-zero, load quotient=6'h3F, remainder=dividend and div_by_zero=1 at edge T, and assert done during the cycle after edge T.
REQ-020 SHALL clear div_by_zero on every non-zero-divisor result load.
REQ-021 SHALL ignore start in RUN and DONE, with no effect on the operation in flight.
REQ-022 SHALL accept start asserted in the cycle after done, since IDLE is re-entered; back-to-back throughput is one result per 8 cycles.
REQ-023 SHALL meet the arithmetic invariant dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.
REQ-024 SHALL not modify outputs on operand input changes after the accepted start, since operands are latched.

Reset
REQ-025 SHALL, on rst_n=0, immediately and asynchronously force state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, R=0 and count=0.
REQ-026 SHALL, on reset during RUN or DONE, abort the division; no done pulse SHALL follow reset release.
REQ-027 SHALL honour start in the first clock edge after rst_n rises.

Structure
REQ-028 SHALL take WIDTH=6, the FSM state encoding (IDLE/RUN/DONE) and the divide-by-zero quotient constant 6'h3F from the shared package div_pkg.
REQ-029 SHALL instantiate one combinational sub-module, sub_7bit (7-bit subtractor with borrow_out, built from the team's 1-bit full-adder cell with inverted subtrahend and carry-in 1), for the trial subtraction.
REQ-030 SHALL contain no other arithmetic operators for the datapath subtraction.

Verification
REQ-031 SHALL verify: start with 45/7 at edge T -> busy at T..T+6; done in the cycle after T+6; quotient=6, remainder=3, div_by_zero=0.
REQ-032 SHALL verify: 63/1 -> quotient=63, remainder=0; and 5/9 -> quotient=0, remainder=5; both with done 7 cycles after start.
REQ-033 SHALL verify: 20/0 -> done in the cycle after start; quotient=6'h3F, remainder=20, div_by_zero=1; a following 20/4 -> quotient=5, remainder=0, div_by_zero=0.
REQ-034 SHALL verify: 60/7 started, then start=1 with 9/3 at T+3 -> only one done; result quotient=8, remainder=4.
REQ-035 SHALL verify: rst_n pulsed low at T+3 of 45/7 -> all outputs 0 immediately; no done afterwards; a new 12/5 -> quotient=2, remainder=2.
REQ-036 SHALL verify: exhaustive or random sweep of all 4032 non-zero-divisor pairs, with the REQ-023 invariant checked on every done.
